// File: rtl/hazard_detection_unit_pkg.sv
// rtl/hazard_detection_unit_pkg.sv - shared constants and FSM encoding for the ID-stage hazard unit
package hazard_detection_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH      = 2'd2;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd3;

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// rtl/hazard_detection_unit_sat_counter.sv - saturating up-counter with synchronous active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - load-use bubble, branch flush and memory freeze control for the ID stage
module hazard_detection_unit #(
  parameter int REG_ADDR_W   = hazard_detection_unit_pkg::REG_ADDR_W,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  if_id_uses_rt,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  ctrl_sel_n,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  pipe_freeze,
  output logic [CNT_W-1:0]      stall_count
);

  import hazard_detection_unit_pkg::*;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic       lu;
  logic       flush_pending;

  always_comb begin
    lu = id_ex_mem_read && (id_ex_rt != REG_ADDR_W'(ZERO_REG)) &&
         ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    // A freeze that interrupted a flush resumes it in the very cycle mem_busy drops,
    // so the wrong-path instruction held in IF/ID is never passed on.
    flush_pending = ((state_q == ST_FLUSH) || (state_q == ST_MEM_WAIT)) && (flush_cnt_q != 2'd0);

    ctrl_sel_n  = 1'b1;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    pipe_freeze = 1'b0;
    state_d     = ST_RUN;
    flush_cnt_d = flush_cnt_q;

    if (!rst_n) begin
      flush_cnt_d = 2'd0;
    end else if (mem_busy) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      state_d     = ST_MEM_WAIT;
    end else if (branch_taken || flush_pending) begin
      if_id_flush = 1'b1;
      ctrl_sel_n  = 1'b0;
      flush_cnt_d = branch_taken ? FLUSH_INIT : (flush_cnt_q - 2'd1);
      state_d     = (flush_cnt_d != 2'd0) ? ST_FLUSH : ST_RUN;
    end else if (lu) begin
      ctrl_sel_n  = 1'b0;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      state_d     = ST_LOAD_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr_n(rst_n),
    .inc  (~ctrl_sel_n | pipe_freeze),
    .count(stall_count)
  );

endmodule
